// File: rtl/fp_alu.sv
// Single-precision add/subtract with one registered result stage.
// Denormal inputs flush to zero; results round to nearest, ties to even.
module fp_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic [31:0] out,
    output logic        overflow
);

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign sa = a[31];
    assign sb = b[31] ^ op;
    assign ea = a[30:23];
    assign eb = b[30:23];
    assign fa = a[22:0];
    assign fb = b[22:0];

    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    logic              swap;
    logic              s_big, s_small;
    logic [7:0]        e_big, e_small, diff;
    logic [23:0]       m_big, m_small;
    logic [52:0]       wide;
    logic [26:0]       small_al;
    logic [27:0]       sum;
    logic [4:0]        lzc;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic              round_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic [31:0]       res;
    logic              res_ov;

    always_comb begin
        swap     = ({eb, fb} > {ea, fa});
        s_big    = swap ? sb : sa;
        s_small  = swap ? sa : sb;
        e_big    = swap ? eb : ea;
        e_small  = swap ? ea : eb;
        m_big    = swap ? {1'b1, fb} : {1'b1, fa};
        m_small  = swap ? {1'b1, fa} : {1'b1, fb};
        diff     = e_big - e_small;

        // Aligned smaller mantissa: 24 bits + guard + round, sticky in bit 0.
        wide     = {m_small, 29'd0} >> diff;
        small_al = (diff >= 8'd26) ? 27'd1 : {wide[52:27], |wide[26:0]};

        if (s_big == s_small)
            sum = {1'b0, m_big, 3'b000} + {1'b0, small_al};
        else
            sum = {1'b0, m_big, 3'b000} - {1'b0, small_al};

        lzc = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lzc = 5'(26 - i);

        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lzc;
            exp_n = $signed({2'b00, e_big}) - $signed({5'd0, lzc});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        exp_r    = mant_r[24] ? exp_n + 10'sd1 : exp_n;
        frac     = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

        res    = 32'd0;
        res_ov = 1'b0;
        if (a_nan || b_nan) begin
            res = 32'h7FC00000;
        end else if (a_inf && b_inf && (sa != sb)) begin
            res = 32'h7FC00000;
        end else if (a_inf) begin
            res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            res = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            res = {sa & sb, 31'd0};
        end else if (a_zero) begin
            res = {sb, b[30:0]};
        end else if (b_zero) begin
            res = {sa, a[30:0]};
        end else if (sum == 28'd0) begin
            res = 32'd0;
        end else if (exp_r >= 10'sd255) begin
            res    = {s_big, 8'hFF, 23'd0};
            res_ov = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            res = {s_big, 31'd0};
        end else begin
            res = {s_big, exp_r[7:0], frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= 32'd0;
            overflow <= 1'b0;
        end else begin
            out      <= res;
            overflow <= res_ov;
        end
    end

endmodule

// File: tb/tb_fp_alu.sv
// Bench for fp_alu: directed cases plus random pairs against an exact-integer
// binary32 reference (round to nearest even, flush to zero).
module tb_fp_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        op;
    logic [31:0] out;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    fp_alu dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .op       (op),
        .out      (out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Returns {overflow, result}. Operands become exact integers in units of
    // 2^-149, are summed exactly, then rounded once.
    function automatic logic [32:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic sx, sy, sign;
        logic [7:0] ex, ey;
        logic [22:0] fx, fy;
        logic signed [299:0] vx, vy, r;
        logic [299:0] mag, q, rem, half, one;
        int p, sh, be;
        sx = x[31]; sy = y[31] ^ sub;
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0]; fy = y[22:0];
        if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0)) return {1'b0, 32'h7FC00000};
        if (ex == 8'hFF && ey == 8'hFF && sx != sy) return {1'b0, 32'h7FC00000};
        if (ex == 8'hFF) return {1'b0, sx, 8'hFF, 23'd0};
        if (ey == 8'hFF) return {1'b0, sy, 8'hFF, 23'd0};
        if (ex == 0 && ey == 0) return {1'b0, sx & sy, 31'd0};
        if (ex == 0) return {1'b0, sy, y[30:0]};
        if (ey == 0) return {1'b0, sx, x[30:0]};
        vx = 0; vx[23:0] = {1'b1, fx}; vx = vx << (ex - 1);
        vy = 0; vy[23:0] = {1'b1, fy}; vy = vy << (ey - 1);
        if (sx) vx = -vx;
        if (sy) vy = -vy;
        r = vx + vy;
        if (r == 0) return {1'b0, 32'd0};
        sign = r[299];
        mag  = sign ? -r : r;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {1'b0, sign, 31'd0};
        sh  = p - 23;
        q   = mag >> sh;
        rem = mag - (q << sh);
        if (sh > 0) begin
            one  = 1;
            half = one << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q[24]) begin
            q  = q >> 1;
            sh = sh + 1;
        end
        be = sh + 1;
        if (be >= 255) return {1'b1, sign, 8'hFF, 23'd0};
        return {1'b0, sign, be[7:0], q[22:0]};
    endfunction

    task automatic apply(input logic [31:0] ta, input logic [31:0] tb_v, input logic top);
        a  = ta;
        b  = tb_v;
        op = top;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] exp_out, input logic exp_ov);
        total++;
        assert (out === exp_out && overflow === exp_ov)
        else begin
            bad++;
            $error("FAIL %s a=%h b=%h op=%b got out=%h ov=%b want out=%h ov=%b",
                   tag, a, b, op, out, overflow, exp_out, exp_ov);
        end
    endtask

    function automatic logic [31:0] rand_operand(input int kind, input logic [31:0] other);
        logic [31:0] v;
        int e;
        v = $urandom;
        case (kind)
            1: v = {1'($urandom_range(0, 1)), other[30:0] ^ 31'($urandom_range(0, 15))};
            2: begin
                e = int'(other[30:23]) + ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(20, 40));
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                v[30:23] = 8'(e);
            end
            3: v[30:23] = 8'($urandom_range(250, 254));
            4: case ($urandom_range(0, 4))
                   0: v[30:23] = 8'h00;
                   1: v[30:0]  = {8'hFF, 23'd0};
                   2: v[30:23] = 8'hFF;
                   3: v[30:0]  = 31'd0;
                   default: v[30:23] = other[30:23];
               endcase
            default: ;
        endcase
        return v;
    endfunction

    logic [32:0] exp_v;
    logic [31:0] ra, rb;
    int kind;

    initial begin
        rst = 1'b1; a = 32'h3F800000; b = 32'h40000000; op = 1'b0;
        @(posedge clk); #1;
        check("reset_edge1", 32'h00000000, 1'b0);
        @(posedge clk); #1;
        check("reset_edge2", 32'h00000000, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release", 32'h40400000, 1'b0);

        apply(32'h3F800000, 32'h40000000, 1'b0); check("add_1_2", 32'h40400000, 1'b0);
        apply(32'h40400000, 32'h3F800000, 1'b1); check("sub_3_1", 32'h40000000, 1'b0);
        apply(32'h3F800000, 32'h3F800000, 1'b1); check("cancel", 32'h00000000, 1'b0);
        apply(32'h3F800000, 32'h33800000, 1'b0); check("tie_even_down", 32'h3F800000, 1'b0);
        apply(32'h3F800001, 32'h33800000, 1'b0); check("tie_even_up", 32'h3F800002, 1'b0);
        apply(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0); check("ovf_pos", 32'h7F800000, 1'b1);
        apply(32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1); check("ovf_neg", 32'hFF800000, 1'b1);
        apply(32'h7F800000, 32'h7F800000, 1'b1); check("inf_minus_inf", 32'h7FC00000, 1'b0);
        apply(32'h7FC00001, 32'h12345678, 1'b0); check("nan_in", 32'h7FC00000, 1'b0);
        apply(32'h00400000, 32'h3F800000, 1'b0); check("denorm_ftz", 32'h3F800000, 1'b0);
        apply(32'h80000000, 32'h00000000, 1'b1); check("negzero_sum", 32'h80000000, 1'b0);
        apply(32'h00000000, 32'h40000000, 1'b1); check("zero_minus_x", 32'hC0000000, 1'b0);
        apply(32'hFF800000, 32'h3F800000, 1'b0); check("neg_inf_pass", 32'hFF800000, 1'b0);

        rst = 1'b1;
        apply(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0); check("reset_priority", 32'h00000000, 1'b0);
        rst = 1'b0;
        apply(32'h40000000, 32'h3F800000, 1'b0); check("reset_midop", 32'h40400000, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            kind = $urandom_range(0, 4);
            ra = $urandom;
            if (kind == 3) ra[30:23] = 8'($urandom_range(250, 254));
            else if (ra[30:23] == 8'hFF) ra[30:23] = 8'h80;
            rb = rand_operand(kind, ra);
            exp_v = ref_model(ra, rb, 1'(i));
            apply(ra, rb, 1'(i));
            check("random", exp_v[31:0], exp_v[32]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
